sdpram_burst_ctrl: RTL and testbench

- Initiator for the simple dual-port RAM. Converts burst commands (start address, length, direction) into port-A write strobes and port-B read strobes.
- Streams write data in and read data out over valid/ready handshakes.
- Tracks the RAM's read pipeline with a tag shift register and buffers returned words in a small FIFO, so read backpressure never loses data.
- Sits between a DMA/host agent and one RAM instance, one controller per RAM.

---
 rtl/sdpram_burst_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sdpram_burst_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_burst_ctrl.sv
// Burst initiator for a simple dual-port RAM: port-A write bursts, port-B read bursts
// with tag-tracked read pipeline and credit-limited return FIFO. Optional: SDPC_BOUNDS_CHK_EN.
module sdpram_burst_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned RD_LATENCY  = 3,
  parameter int unsigned RFIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  err,
  output logic                  wena,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dina,
  output logic                  renb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  input  logic                  dvalb
);

  localparam int unsigned CNT_W  = LEN_WIDTH + 1;
  localparam int unsigned PTR_W  = (RFIFO_DEPTH > 1) ? $clog2(RFIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(RFIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_n, addra_n, addrb_n;
  logic [CNT_W-1:0]      remain, remain_n;
  logic [DATA_WIDTH-1:0] dina_n;
  logic                  wena_n, renb_n, rtag, rtag_n;
  logic                  cmd_ready_n, wr_ready_n, busy_n, err_n;
  logic [RD_LATENCY-1:0] tag_sr, tag_sr_n;
  logic                  credit_ok, oob;

  logic [DATA_WIDTH-1:0] fifo_mem [RFIFO_DEPTH];
  logic [PTR_W-1:0]      wptr, rptr, wptr_n, rptr_n;
  logic [FCNT_W-1:0]     fcount, fcount_n;
  logic                  push, pop;

  // dvalb is sticky in the RAM, so alignment relies solely on the tag pipeline
  logic unused_dvalb;
  assign unused_dvalb = dvalb;

`ifdef SDPC_BOUNDS_CHK_EN
  localparam int unsigned SUM_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 2;
  assign oob = (SUM_W'(cmd_addr) + SUM_W'(cmd_len) + SUM_W'(1)) > (SUM_W'(1) << ADDR_WIDTH);
`else
  assign oob = 1'b0;
`endif

  assign push     = tag_sr[RD_LATENCY-1];
  assign rd_valid = (fcount != '0);
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = fifo_mem[rptr];

  // Outstanding = buffered + in pipeline + strobe currently on renb; issue only if one more fits
  assign credit_ok = (32'(fcount) + 32'($countones(tag_sr)) + 32'(renb & rtag) + 32'd1)
                     <= 32'(RFIFO_DEPTH);

  always_comb begin
    state_n    = state;
    cur_addr_n = cur_addr;
    remain_n   = remain;
    wena_n     = 1'b0;
    addra_n    = addra;
    dina_n     = dina;
    renb_n     = 1'b0;
    addrb_n    = addrb;
    rtag_n     = 1'b0;
    err_n      = 1'b0;
    wptr_n     = wptr;
    rptr_n     = rptr;
    fcount_n   = fcount;

    // Tags advance with the RAM pipeline; a captured tail tag is retired even without a shift
    if (renb) begin
      tag_sr_n = RD_LATENCY'({tag_sr, rtag});
    end else begin
      tag_sr_n = tag_sr;
      tag_sr_n[RD_LATENCY-1] = 1'b0;
    end

    if (push) wptr_n = (wptr == PTR_W'(RFIFO_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
    if (pop)  rptr_n = (rptr == PTR_W'(RFIFO_DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
    case ({push, pop})
      2'b10:   fcount_n = fcount + FCNT_W'(1);
      2'b01:   fcount_n = fcount - FCNT_W'(1);
      default: fcount_n = fcount;
    endcase

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (oob) begin
            err_n = 1'b1;
          end else begin
            cur_addr_n = cmd_addr;
            remain_n   = CNT_W'(cmd_len) + CNT_W'(1);
            state_n    = cmd_wr ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        if (wr_valid && wr_ready) begin
          wena_n     = 1'b1;
          addra_n    = cur_addr;
          dina_n     = wr_data;
          cur_addr_n = cur_addr + ADDR_WIDTH'(1);
          remain_n   = remain - CNT_W'(1);
          if (remain == CNT_W'(1)) state_n = IDLE;
        end
      end
      READ: begin
        if (credit_ok) begin
          renb_n     = 1'b1;
          addrb_n    = cur_addr;
          rtag_n     = 1'b1;
          cur_addr_n = cur_addr + ADDR_WIDTH'(1);
          remain_n   = remain - CNT_W'(1);
          if (remain == CNT_W'(1)) state_n = DRAIN;
        end
      end
      DRAIN: begin
        // Dummy strobes push the last real words out of the RAM pipeline
        if (tag_sr_n != '0) renb_n = 1'b1;
        else                state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    cmd_ready_n = (state_n == IDLE);
    wr_ready_n  = (state_n == WRITE);
    busy_n      = (state_n != IDLE) | (tag_sr_n != '0) | (fcount_n != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remain    <= '0;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      wena      <= 1'b0;
      addra     <= '0;
      dina      <= '0;
      renb      <= 1'b0;
      addrb     <= '0;
      rtag      <= 1'b0;
      tag_sr    <= '0;
      wptr      <= '0;
      rptr      <= '0;
      fcount    <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cur_addr  <= cur_addr_n;
      remain    <= remain_n;
      cmd_ready <= cmd_ready_n;
      wr_ready  <= wr_ready_n;
      wena      <= wena_n;
      addra     <= addra_n;
      dina      <= dina_n;
      renb      <= renb_n;
      addrb     <= addrb_n;
      rtag      <= rtag_n;
      tag_sr    <= tag_sr_n;
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      fcount    <= fcount_n;
      busy      <= busy_n;
      err       <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wptr] <= doutb;
  end

endmodule

// File: tb/tb_sdpram_burst_ctrl.sv
// Scoreboard bench for sdpram_burst_ctrl with a behavioural RAM (renb-advanced read pipeline).
module tb_sdpram_burst_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 8;
  localparam int unsigned L  = 3;
  localparam int unsigned D  = 4;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy, err, wena, renb, dvalb;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, doutb;

  sdpram_burst_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .RD_LATENCY(L), .RFIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .err(err),
    .wena(wena), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(doutb), .dvalb(dvalb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read pipeline advances only on renb edges
  logic [DW-1:0] mem  [1 << AW];
  logic [DW-1:0] pipe [L];
  assign doutb = pipe[L-1];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    for (int i = 0; i < int'(L); i++) pipe[i] = '0;
    dvalb = 1'b0;
  end

  always @(posedge clk) begin
    if (wena) mem[addra] <= dina;
    if (renb) begin
      pipe[0] <= mem[addrb];
      for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
      dvalb <= 1'b1;
    end
  end

  logic [AW+DW-1:0] exp_wr [$];
  logic [DW-1:0]    exp_rd [$];
  logic [AW+DW-1:0] e_wr;
  logic [DW-1:0]    e_rd;
  int checks, errors;
  int wena_cnt, wena_run, wena_max, err_cnt, renb_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write strobe or a read word
  always @(negedge clk) begin
    if (!rst) begin
      if (wena) begin
        wena_cnt++;
        wena_run++;
        if (wena_run > wena_max) wena_max = wena_run;
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", addra, dina);
        end else begin
          e_wr = exp_wr.pop_front();
          chk("write", {addra, dina}, 64'(e_wr));
        end
      end else begin
        wena_run = 0;
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got %0h expected none", rd_data);
        end else begin
          e_rd = exp_rd.pop_front();
          chk("read_data", 64'(rd_data), 64'(e_rd));
        end
      end
      if (err)  err_cnt++;
      if (renb) renb_cnt++;
    end
  end

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] len);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = len;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL cmd_timeout: got cmd_ready 0 expected 1"); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int len, input logic [DW-1:0] base,
                          input bit gap);
    bit ok;
    for (int i = 0; i <= len; i++) exp_wr.push_back({AW'(a + AW'(i)), DW'(base + DW'(i))});
    send_cmd(1'b1, a, LW'(len));
    for (int i = 0; i <= len; i++) begin
      wr_valid = 1'b1; wr_data = base + DW'(i);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (wr_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin checks++; errors++; $display("FAIL wr_timeout: got wr_ready 0 expected 1"); end
      @(posedge clk); #1;
      wr_valid = 1'b0;
      if (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic push_rd(input logic [DW-1:0] base, input int len);
    for (int i = 0; i <= len; i++) exp_rd.push_back(base + DW'(i));
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy && cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL idle_timeout: got busy %0b expected 0", busy); end
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;
    checks = 0; errors = 0;
    wena_cnt = 0; wena_run = 0; wena_max = 0; err_cnt = 0; renb_cnt = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_wr_ready",  64'(wr_ready),  64'd0);
    chk("rst_wena",      64'(wena),      64'd0);
    chk("rst_renb",      64'(renb),      64'd0);
    chk("rst_rd_valid",  64'(rd_valid),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_err",       64'(err),       64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back write burst
    wena_cnt = 0; wena_max = 0;
    do_write(10'h010, 3, 32'hA0, 1'b0);
    wait_idle();
    chk("t1_wena_count", 64'(wena_cnt), 64'd4);
    chk("t1_wena_run",   64'(wena_max), 64'd4);
    chk("t1_wr_drained", 64'(exp_wr.size()), 64'd0);

    // Read burst with free-flowing consumer
    rd_ready = 1'b1;
    push_rd(32'hA0, 3);
    send_cmd(1'b0, 10'h010, 8'd3);
    wait_idle();
    chk("t2_rd_drained", 64'(exp_rd.size()), 64'd0);
    chk("t2_rd_valid",   64'(rd_valid), 64'd0);

    // Same read with consumer stalled for 20 cycles
    rd_ready = 1'b0;
    push_rd(32'hA0, 3);
    send_cmd(1'b0, 10'h010, 8'd3);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t3_held_words", 64'(exp_rd.size()), 64'd4);
    chk("t3_rd_valid",   64'(rd_valid), 64'd1);
    chk("t3_busy",       64'(busy), 64'd1);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    wait_idle();
    chk("t3_rd_drained", 64'(exp_rd.size()), 64'd0);

    // Write with wr_valid toggling every other cycle
    wena_cnt = 0;
    do_write(10'h020, 7, 32'hB0, 1'b1);
    wait_idle();
    chk("t6_wena_count", 64'(wena_cnt), 64'd8);
    chk("t6_wr_drained", 64'(exp_wr.size()), 64'd0);

    // Longer read with stalled consumer: strobes bounded by FIFO credits
    rd_ready = 1'b0;
    renb_cnt = 0;
    push_rd(32'hB0, 7);
    send_cmd(1'b0, 10'h020, 8'd7);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t3b_credit_bound", 64'(renb_cnt <= int'(D)), 64'd1);
    chk("t3b_rd_valid",     64'(rd_valid), 64'd1);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    wait_idle();
    chk("t3b_rd_drained", 64'(exp_rd.size()), 64'd0);

    // Burst crossing the top of the address space
`ifdef SDPC_BOUNDS_CHK_EN
    wena_cnt = 0; err_cnt = 0;
    send_cmd(1'b1, 10'h3FE, 8'd3);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_err_pulses", 64'(err_cnt), 64'd1);
    chk("t4_no_wena",    64'(wena_cnt), 64'd0);
    chk("t4_cmd_ready",  64'(cmd_ready), 64'd1);
`else
    do_write(10'h3FE, 3, 32'hC0, 1'b0);
    wait_idle();
    chk("t4_wr_drained", 64'(exp_wr.size()), 64'd0);
    push_rd(32'hC0, 3);
    send_cmd(1'b0, 10'h3FE, 8'd3);
    wait_idle();
    chk("t4_rd_drained", 64'(exp_rd.size()), 64'd0);
`endif

    // Reset in the middle of a read burst
    rd_ready = 1'b1;
    send_cmd(1'b0, 10'h010, 8'd3);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      if (renb) n++;
      if (n == 2) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL t5_strobe_timeout: got %0d strobes expected 2", n); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd.delete();
    @(negedge clk);
    chk("t5_renb",      64'(renb),      64'd0);
    chk("t5_rd_valid",  64'(rd_valid),  64'd0);
    chk("t5_busy",      64'(busy),      64'd0);
    chk("t5_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    push_rd(32'hA0, 3);
    send_cmd(1'b0, 10'h010, 8'd3);
    wait_idle();
    chk("t5_rd_drained", 64'(exp_rd.size()), 64'd0);

`ifndef SDPC_BOUNDS_CHK_EN
    chk("err_never", 64'(err_cnt), 64'd0);
`endif
    chk("final_wr_queue", 64'(exp_wr.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
